// File: rtl/decode_stage.sv
// RV32I decode stage with valid/ready on both sides, optional skid entry and flush.
// Define DECODE_RV32M_EN to decode the M-extension (OP with funct7=0000001).
module decode_stage #(
    parameter int PC_W = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] pc_in,
    input  logic            jump_branch_enable,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic [31:0]     imm,
    output logic [10:0]     op_class,
    output logic [5:0]      br_type,
    output logic [4:0]      alu_op,
    output logic [2:0]      mem_size,
    output logic            illegal
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic [31:0]     imm;
        logic [10:0]     op_class;
        logic [5:0]      br_type;
        logic [4:0]      alu_op;
        logic [2:0]      mem_size;
        logic            illegal;
    } bundle_t;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Classes that write rd: LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP.
    localparam logic [10:0] WRITES_RD = 11'b00110101111;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SRA  = 5'd7;

    // Base funct3 mapping; alt selects SUB for 000 and SRA for 101.
    function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = 5'd2;
            3'b010:  op = 5'd3;
            3'b011:  op = 5'd4;
            3'b100:  op = 5'd5;
            3'b101:  op = alt ? ALU_SRA : 5'd6;
            3'b110:  op = 5'd8;
            default: op = 5'd9;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [10:0] dec_class;
    logic [31:0] dec_imm;
    logic [5:0]  dec_br;
    logic [4:0]  dec_alu;
    logic [2:0]  dec_mem;
    logic        dec_ill;
    bundle_t     dec;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        dec_class = '0;
        dec_imm   = '0;
        dec_br    = '0;
        dec_alu   = ALU_ADD;
        dec_mem   = '0;
        dec_ill   = 1'b0;
        case (opcode)
            OPC_LUI:   begin dec_class[0] = 1'b1; dec_imm = imm_u; end
            OPC_AUIPC: begin dec_class[1] = 1'b1; dec_imm = imm_u; end
            OPC_JAL:   begin dec_class[2] = 1'b1; dec_imm = imm_j; end
            OPC_JALR: begin
                dec_class[3] = 1'b1;
                dec_imm      = imm_i;
                dec_ill      = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_class[4] = 1'b1;
                dec_imm      = imm_b;
                case (funct3)
                    3'b000:  dec_br[0] = 1'b1;
                    3'b001:  dec_br[1] = 1'b1;
                    3'b100:  dec_br[2] = 1'b1;
                    3'b101:  dec_br[3] = 1'b1;
                    3'b110:  dec_br[4] = 1'b1;
                    3'b111:  dec_br[5] = 1'b1;
                    default: dec_ill   = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_class[5] = 1'b1;
                dec_imm      = imm_i;
                dec_mem      = funct3;
                dec_ill      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_class[6] = 1'b1;
                dec_imm      = imm_s;
                dec_mem      = funct3;
                dec_ill      = (funct3 >= 3'b011);
            end
            OPC_OPIMM: begin
                dec_class[7] = 1'b1;
                dec_imm      = imm_i;
                dec_alu      = alu_from_funct3(funct3, (funct3 == 3'b101) && instruction[30]);
                if (funct3 == 3'b001)
                    dec_ill = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    dec_ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_OP: begin
                dec_class[8] = 1'b1;
                case (funct7)
                    7'b0000000: dec_alu = alu_from_funct3(funct3, 1'b0);
                    7'b0100000: begin
                        dec_alu = alu_from_funct3(funct3, 1'b1);
                        dec_ill = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: dec_alu = 5'd10 + {2'b00, funct3};
`endif
                    default:    dec_ill = 1'b1;
                endcase
            end
            OPC_MISCMEM: dec_class[9]  = 1'b1;
            OPC_SYSTEM:  dec_class[10] = 1'b1;
            default:     dec_ill       = 1'b1;
        endcase

        // Illegal words keep only pc and raw register fields for the trap path.
        dec          = '0;
        dec.pc       = pc_in;
        dec.rs1      = instruction[19:15];
        dec.rs2      = instruction[24:20];
        dec.rd       = instruction[11:7];
        dec.illegal  = dec_ill;
        if (!dec_ill) begin
            dec.op_class = dec_class;
            dec.imm      = dec_imm;
            dec.br_type  = dec_br;
            dec.alu_op   = dec_alu;
            dec.mem_size = dec_mem;
            dec.rd_we    = |(dec_class & WRITES_RD) && (instruction[11:7] != 5'd0);
        end
    end

    bundle_t out_q, skid_q;
    logic    out_valid_q, skid_valid_q;
    logic    out_free, accept;

    assign out_free = ~out_valid_q | out_ready;
    assign in_ready = ~reset & ((SKID != 0) ? ~skid_valid_q : out_free);
    assign accept   = in_valid & in_ready;

    // Output register refills from skid first so ordering is preserved;
    // new words only land in skid while the output register is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (jump_branch_enable) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= accept;
                if (accept)
                    out_q <= dec;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign pc_out    = out_q.pc;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign rd        = out_q.rd;
    assign rd_we     = out_q.rd_we;
    assign imm       = out_q.imm;
    assign op_class  = out_q.op_class;
    assign br_type   = out_q.br_type;
    assign alu_op    = out_q.alu_op;
    assign mem_size  = out_q.mem_size;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a scoreboard plus
// hand sequences for skid backpressure, flush and reset-while-stalled.
module tb_decode_stage;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic [10:0] cls;
        logic [5:0]  br;
        logic [4:0]  alu;
        logic [2:0]  mem;
        logic        ill;
    } dec_t;

    typedef struct packed {
        dec_t        d;
        logic [31:0] pc;
    } item_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, jump_branch_enable, out_valid, out_ready;
    logic [31:0] instruction, pc_in, pc_out, imm;
    logic [4:0]  rs1, rs2, rd, alu_op;
    logic        rd_we, illegal;
    logic [10:0] op_class;
    logic [5:0]  br_type;
    logic [2:0]  mem_size;

    int    checks = 0;
    int    fails  = 0;
    item_t sb[$];
    dec_t  cur_exp;
    vec_t  vecs[21];
    bit    stim_done;
    item_t snap;

    decode_stage #(.PC_W(32), .SKID(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in), .jump_branch_enable(jump_branch_enable),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .imm(imm), .op_class(op_class),
        .br_type(br_type), .alu_op(alu_op), .mem_size(mem_size), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic dec_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                                input logic we, input logic [31:0] im, input logic [10:0] cl,
                                input logic [5:0] br, input logic [4:0] al, input logic [2:0] ms,
                                input logic il);
        dec_t r;
        r = '{rs1: a, rs2: b, rd: c, rd_we: we, imm: im, cls: cl, br: br, alu: al, mem: ms, ill: il};
        return r;
    endfunction

    function automatic item_t actual();
        item_t r;
        r = {rs1, rs2, rd, rd_we, imm, op_class, br_type, alu_op, mem_size, illegal, pc_out};
        return r;
    endfunction

    task automatic checkOutput(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s got %h required %h", nm, act, req);
        end
    endtask

    // Holds a word on the input until it is accepted, then drops in_valid.
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc, input dec_t e);
        bit got;
        got         = 1'b0;
        instruction = ins;
        pc_in       = pc;
        cur_exp     = e;
        in_valid    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            fails++;
            $display("[TB] FAIL accept_timeout pc=%h got in_ready=0 required 1", pc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string nm);
        for (int k = 0; k < 40 && sb.size() != 0; k++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput(nm, 128'(sb.size()), 128'd0);
    endtask

    // Scoreboard: pop on output transfer, push on accept, discard on flush/reset.
    always @(negedge clk) begin
        item_t act, exp_i;
        if (!reset && out_valid && out_ready) begin
            checks++;
            act = actual();
            if (sb.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_output got %h required none", act);
            end else begin
                exp_i = sb.pop_front();
                if (act !== exp_i) begin
                    fails++;
                    $display("[TB] FAIL bundle pc=%h got %h required %h", exp_i.pc, act, exp_i);
                end
            end
        end
        if (reset || jump_branch_enable)
            sb.delete();
        else if (in_valid && in_ready)
            sb.push_back({cur_exp, pc_in});
    end

    initial begin
        #400000;
        fails++;
        $display("[TB] FAIL watchdog got timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; instruction = '0; pc_in = '0;
        jump_branch_enable = 1'b0; out_ready = 1'b0; cur_exp = '0; stim_done = 1'b0;

        //                    rs1 rs2 rd we imm            class     br     alu mem ill
        vecs[0]  = '{32'h00500093, mk(0, 5, 1, 1, 32'd5,        11'h080, 6'h00, 0, 0, 0)};
        vecs[1]  = '{32'hFE208EE3, mk(1, 2, 29, 0, 32'hFFFFFFFC, 11'h010, 6'h01, 0, 0, 0)};
        vecs[2]  = '{32'h00812283, mk(2, 8, 5, 1, 32'd8,        11'h020, 6'h00, 0, 2, 0)};
        vecs[3]  = '{32'hFE61AC23, mk(3, 6, 24, 0, 32'hFFFFFFF8, 11'h040, 6'h00, 0, 2, 0)};
        vecs[4]  = '{32'h123453B7, mk(8, 3, 7, 1, 32'h12345000, 11'h001, 6'h00, 0, 0, 0)};
        vecs[5]  = '{32'h010000EF, mk(0, 16, 1, 1, 32'd16,      11'h004, 6'h00, 0, 0, 0)};
        vecs[6]  = '{32'h00008067, mk(1, 0, 0, 0, 32'd0,        11'h008, 6'h00, 0, 0, 0)};
        vecs[7]  = '{32'h402081B3, mk(1, 2, 3, 1, 32'd0,        11'h100, 6'h00, 1, 0, 0)};
        vecs[8]  = '{32'h40325213, mk(4, 3, 4, 1, 32'h403,      11'h080, 6'h00, 7, 0, 0)};
        vecs[9]  = '{32'h0062E463, mk(5, 6, 8, 0, 32'd8,        11'h010, 6'h10, 0, 0, 0)};
        vecs[10] = '{32'h00000000, mk(0, 0, 0, 0, 32'd0,        11'h000, 6'h00, 0, 0, 1)};
`ifdef DECODE_RV32M_EN
        vecs[11] = '{32'h022080B3, mk(1, 2, 1, 1, 32'd0,        11'h100, 6'h00, 10, 0, 0)};
`else
        vecs[11] = '{32'h022080B3, mk(1, 2, 1, 0, 32'd0,        11'h000, 6'h00, 0, 0, 1)};
`endif
        vecs[12] = '{32'h00003083, mk(0, 0, 1, 0, 32'd0,        11'h000, 6'h00, 0, 0, 1)};
        vecs[13] = '{32'h00009067, mk(1, 0, 0, 0, 32'd0,        11'h000, 6'h00, 0, 0, 1)};
        vecs[14] = '{32'h00000073, mk(0, 0, 0, 0, 32'd0,        11'h400, 6'h00, 0, 0, 0)};
        vecs[15] = '{32'h0FF0000F, mk(0, 31, 0, 0, 32'd0,       11'h200, 6'h00, 0, 0, 0)};
        vecs[16] = '{32'h40101093, mk(0, 1, 1, 0, 32'd0,        11'h000, 6'h00, 0, 0, 1)};
        vecs[17] = '{32'h00001517, mk(0, 0, 10, 1, 32'h1000,    11'h002, 6'h00, 0, 0, 0)};
        vecs[18] = '{32'h007372B3, mk(6, 7, 5, 1, 32'd0,        11'h100, 6'h00, 9, 0, 0)};
        vecs[19] = '{32'h40209133, mk(1, 2, 2, 0, 32'd0,        11'h000, 6'h00, 0, 0, 1)};
        vecs[20] = '{32'h00500090, mk(0, 5, 1, 0, 32'd0,        11'h000, 6'h00, 0, 0, 1)};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_bundle", 128'(actual()), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 128'(in_ready), 128'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++)
            applyStimulus(vecs[i].instr, 32'h1000 + 32'(i * 4), vecs[i].e);
        waitDrain("drain_table");

        // Same table under random backpressure exercises the skid path.
        fork
            begin
                for (int i = 0; i < 21; i++)
                    applyStimulus(vecs[i].instr, 32'h8000 + 32'(i * 4), vecs[i].e);
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        waitDrain("drain_random");
        @(posedge clk); #1;

        // Three words into a stalled stage: second fills skid, third waits.
        out_ready = 1'b0;
        applyStimulus(vecs[0].instr, 32'h2000, vecs[0].e);
        checkOutput("in_ready_one_held", 128'(in_ready), 128'd1);
        applyStimulus(vecs[2].instr, 32'h2004, vecs[2].e);
        @(negedge clk);
        checkOutput("in_ready_skid_full", 128'(in_ready), 128'd0);
        snap = actual();
        @(negedge clk);
        checkOutput("stall_stable", 128'(actual()), 128'(snap));
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(vecs[7].instr, 32'h2008, vecs[7].e);
        waitDrain("drain_skid");
        @(posedge clk); #1;

        // Flush with output and skid full and a new word offered.
        out_ready = 1'b0;
        applyStimulus(vecs[4].instr, 32'h3000, vecs[4].e);
        applyStimulus(vecs[5].instr, 32'h3004, vecs[5].e);
        instruction = vecs[8].instr; pc_in = 32'h3008; cur_exp = vecs[8].e;
        in_valid = 1'b1; jump_branch_enable = 1'b1;
        @(posedge clk); #1;
        jump_branch_enable = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_full_out_valid", 128'(out_valid), 128'd0);
        checkOutput("flush_full_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        // Flush coinciding with an output transfer and a same-cycle accept.
        @(posedge clk); #1;
        applyStimulus(vecs[18].instr, 32'h3100, vecs[18].e);
        instruction = vecs[9].instr; pc_in = 32'h3104; cur_exp = vecs[9].e;
        in_valid = 1'b1; jump_branch_enable = 1'b1;
        @(posedge clk); #1;
        jump_branch_enable = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_xfer_out_valid", 128'(out_valid), 128'd0);
        checkOutput("flush_xfer_in_ready", 128'(in_ready), 128'd1);
        repeat (5) @(negedge clk);

        // Reset while the output register is stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(vecs[17].instr, 32'h4000, vecs[17].e);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("midreset_bundle", 128'(actual()), 128'd0);
        checkOutput("midreset_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        applyStimulus(vecs[0].instr, 32'h5000, vecs[0].e);
        waitDrain("drain_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
